// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART for the MEM-stage bus: TXD/RXD/CON registers, 16x
// oversampled receiver, and registered RxRdy/TxRdy interrupt levels.
module uart_mmio #(
    parameter int          CLK_FREQ = 50000000,
    parameter int          BAUD     = 9600,
    parameter int          DIV      = CLK_FREQ / (BAUD * 16),
    parameter logic [31:0] BASE     = 32'h4000_0018
) (
    input  logic        C,
    input  logic        R,
    input  logic [31:0] Addr,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    input  logic        Rx,
    output logic        Tx,
    output logic        RxRdy,
    output logic        TxRdy
);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [29:0] TXD_A = BASE[31:2];
    localparam logic [29:0] RXD_A = TXD_A + 30'd1;
    localparam logic [29:0] CON_A = TXD_A + 30'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          sel_txd, sel_rxd, sel_con, wr_txd, wr_con, rd_rxd, rd_con;
    logic          tx_ie, rx_ie, rx_full, tx_done, frame_err, overrun, tx_busy;
    logic [7:0]    txd_reg, rx_data;
    logic          unused_bits;

    assign unused_bits = ^{Addr[1:0], WrData[31:8]};

    assign tick    = (tick_cnt == TW'(DIV - 1));
    assign sel_txd = (Addr[31:2] == TXD_A);
    assign sel_rxd = (Addr[31:2] == RXD_A);
    assign sel_con = (Addr[31:2] == CON_A);
    assign wr_txd  = MemWr & sel_txd;
    assign wr_con  = MemWr & sel_con;
    assign rd_rxd  = MemRd & sel_rxd;
    assign rd_con  = MemRd & sel_con;

    always_ff @(posedge C or negedge R) begin
        if (!R) tick_cnt <= '0;
        else    tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end

    // ---------------- receiver ----------------
    state_t     rx_state, rx_nxt;
    logic       rx_s1, rxs, rxs_d;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_sh;
    logic       rx_clr, rx_samp, rx_done, rx_ferr;

    always_comb begin
        rx_nxt  = rx_state;
        rx_clr  = 1'b0;
        rx_samp = 1'b0;
        rx_done = 1'b0;
        rx_ferr = 1'b0;
        case (rx_state)
            S_IDLE:  if (rxs_d && !rxs) begin rx_nxt = S_START; rx_clr = 1'b1; end
            // Mid-start-bit check rejects glitches shorter than half a bit.
            S_START: if (tick && rx_tcnt == 4'd7) begin
                rx_nxt = rxs ? S_IDLE : S_DATA;
                rx_clr = 1'b1;
            end
            S_DATA:  if (tick && rx_tcnt == 4'd15) begin
                rx_samp = 1'b1;
                if (rx_bit == 3'd7) rx_nxt = S_STOP;
            end
            S_STOP:  if (tick && rx_tcnt == 4'd15) begin
                rx_nxt  = S_IDLE;
                rx_done = rxs;
                rx_ferr = !rxs;
            end
            default: rx_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            rx_s1     <= 1'b1;
            rxs       <= 1'b1;
            rxs_d     <= 1'b1;
            rx_state  <= S_IDLE;
            rx_tcnt   <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            rx_data   <= '0;
            rx_full   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1    <= Rx;
            rxs      <= rx_s1;
            rxs_d    <= rxs;
            rx_state <= rx_nxt;
            if (rx_clr)    rx_tcnt <= '0;
            else if (tick) rx_tcnt <= rx_tcnt + 4'd1;
            if (rx_clr)       rx_bit <= '0;
            else if (rx_samp) rx_bit <= rx_bit + 3'd1;
            if (rx_samp) rx_sh   <= {rxs, rx_sh[7:1]};
            if (rx_done) rx_data <= rx_sh;
            // Completion beats a same-edge RXD read, so the new byte is not lost.
            if (rx_done)     rx_full <= 1'b1;
            else if (rd_rxd) rx_full <= 1'b0;
            if (rx_done && rx_full && !rd_rxd) overrun <= 1'b1;
            else if (rd_con)                   overrun <= 1'b0;
            if (rx_ferr)     frame_err <= 1'b1;
            else if (rd_con) frame_err <= 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    state_t     tx_state, tx_nxt;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_sh;
    logic       tx_load, tx_done_set, tx_line, tx_line_nxt, tx_bit_end;

    assign tx_busy    = (tx_state != S_IDLE);
    assign tx_bit_end = tick && tx_tcnt == 4'd15;

    always_comb begin
        tx_nxt      = tx_state;
        tx_load     = 1'b0;
        tx_done_set = 1'b0;
        case (tx_state)
            S_IDLE:  if (wr_txd) begin tx_nxt = S_START; tx_load = 1'b1; end
            S_START: if (tx_bit_end) tx_nxt = S_DATA;
            S_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_nxt = S_STOP;
            S_STOP:  if (tx_bit_end) begin tx_nxt = S_IDLE; tx_done_set = 1'b1; end
            default: tx_nxt = S_IDLE;
        endcase
        // Line level is registered from the next state so Tx never glitches.
        case (tx_nxt)
            S_START: tx_line_nxt = 1'b0;
            S_DATA:  tx_line_nxt = (tx_state == S_DATA && tx_bit_end) ? tx_sh[1] : tx_sh[0];
            default: tx_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            tx_state <= S_IDLE;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_line  <= 1'b1;
            txd_reg  <= '0;
            tx_done  <= 1'b0;
            tx_ie    <= 1'b0;
            rx_ie    <= 1'b0;
            RxRdy    <= 1'b0;
            TxRdy    <= 1'b0;
        end else begin
            tx_state <= tx_nxt;
            tx_line  <= tx_line_nxt;
            if (wr_txd) txd_reg <= WrData[7:0];
            if (tx_load) begin
                tx_tcnt <= '0;
                tx_bit  <= '0;
                tx_sh   <= WrData[7:0];
            end else if (tick && tx_busy) begin
                tx_tcnt <= tx_tcnt + 4'd1;
                if (tx_state == S_DATA && tx_tcnt == 4'd15) begin
                    tx_sh  <= tx_sh >> 1;
                    tx_bit <= tx_bit + 3'd1;
                end
            end
            if (tx_done_set) tx_done <= 1'b1;
            else if (rd_con) tx_done <= 1'b0;
            if (wr_con) {rx_ie, tx_ie} <= WrData[1:0];
            RxRdy <= rx_ie & rx_full;
            TxRdy <= tx_ie & tx_done;
        end
    end

    assign Tx = tx_line;

    always_comb begin
        RdData = '0;
        if (sel_txd)      RdData = {24'b0, txd_reg};
        else if (sel_rxd) RdData = {24'b0, rx_data};
        else if (sel_con) RdData = {25'b0, overrun, frame_err, tx_busy, tx_done,
                                    rx_full, rx_ie, tx_ie};
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: bus tasks, serial RX driver, TX line decoder, and
// byte queues holding the expected traffic in each direction.
module tb_uart_mmio;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
    localparam int BIT = 160;

    logic        C = 1'b0, R = 1'b0;
    logic [31:0] Addr = A_CON, WrData = '0, RdData;
    logic        MemRd = 1'b0, MemWr = 1'b0, Rx = 1'b1, Tx, RxRdy, TxRdy;

    always #5 C = ~C;

    uart_mmio #(.CLK_FREQ(1600000), .BAUD(10000)) dut (
        .C(C), .R(R), .Addr(Addr), .MemRd(MemRd), .MemWr(MemWr), .WrData(WrData),
        .RdData(RdData), .Rx(Rx), .Tx(Tx), .RxRdy(RxRdy), .TxRdy(TxRdy)
    );

    int         n_chk = 0, n_pass = 0;
    logic [7:0] tx_q[$], rx_q[$];
    logic [7:0] rxd_model = 8'h00;
    bit         mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge C); Addr = a; WrData = d; MemWr = 1'b1;
        @(negedge C); MemWr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge C); Addr = a; MemRd = 1'b1;
        #1 d = RdData;
        @(negedge C); MemRd = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge C); Rx = 1'b0;
        repeat (BIT) @(negedge C);
        for (int i = 0; i < 8; i++) begin Rx = b[i]; repeat (BIT) @(negedge C); end
        Rx = stop;
        repeat (BIT) @(negedge C);
        Rx = 1'b1;
        repeat (40) @(negedge C);
        if (stop) rx_q.push_back(b);
    endtask

    // Only the most recent good byte survives in RXD.
    task automatic check_rxd(input string tag);
        logic [31:0] d;
        bus_rd(A_RXD, d);
        while (rx_q.size() > 0) rxd_model = rx_q.pop_front();
        chk(tag, d, {24'b0, rxd_model});
    endtask

    task automatic width_of(input logic lvl, output int n);
        n = 0;
        while (Tx == lvl && n < 400) begin @(negedge C); n++; end
    endtask

    // Samples 1.5 bit times past the falling edge; tolerates start-bit tick phase.
    initial begin : tx_mon
        logic prev;
        logic [7:0] got;
        bit act;
        prev = 1'b1;
        forever begin
            @(negedge C);
            if (R && prev && !Tx) begin
                act = mon_en;
                repeat (235) @(negedge C);
                got[0] = Tx;
                for (int i = 1; i < 8; i++) begin repeat (BIT) @(negedge C); got[i] = Tx; end
                repeat (BIT) @(negedge C);
                if (act) begin
                    chk("tx_stop", {31'b0, Tx}, 32'd1);
                    if (tx_q.size() == 0) chk("tx_unexpected", {24'b0, got}, 32'h100);
                    else chk("tx_frame", {24'b0, got}, {24'b0, tx_q.pop_front()});
                end
            end
            prev = Tx;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] d;
        int n, bad;
        bit found;

        // 1. reset state, then reset mid-transmit
        repeat (3) @(negedge C);
        MemRd = 1'b1;
        #1;
        chk("rst_tx", {31'b0, Tx}, 32'd1);
        chk("rst_rxrdy", {31'b0, RxRdy}, 32'd0);
        chk("rst_txrdy", {31'b0, TxRdy}, 32'd0);
        chk("rst_con", RdData, 32'd0);
        MemRd = 1'b0;
        @(negedge C); R = 1'b1;
        bus_wr(A_CON, 32'h3);
        bus_wr(A_TXD, 32'h00);
        repeat (400) @(negedge C);
        bus_rd(A_CON, d);
        chk("con_busy", d, 32'h13);
        chk("tx_low_pre", {31'b0, Tx}, 32'd0);
        @(negedge C); R = 1'b0; Addr = A_CON; MemRd = 1'b1;
        #1;
        chk("rst_mid_tx", {31'b0, Tx}, 32'd1);
        chk("rst_mid_con", RdData, 32'd0);
        chk("rst_mid_irq", {30'b0, RxRdy, TxRdy}, 32'd0);
        MemRd = 1'b0;
        @(negedge C); R = 1'b1;
        bad = 0;
        repeat (300) begin @(negedge C); if (!Tx) bad++; end
        chk("tx_idle_post_rst", bad, 0);
        repeat (1000) @(negedge C);
        mon_en = 1'b1;

        // 2. transmit 0xA5 with TxIntEn
        bus_wr(A_CON, 32'h1);
        bus_wr(A_TXD, 32'hA5);
        tx_q.push_back(8'hA5);
        width_of(1'b0, n);
        chk("start_w_ok", {31'b0, (n >= 150 && n <= 161)}, 32'd1);
        width_of(1'b1, n);
        chk("bit0_w_ok", {31'b0, (n >= 159 && n <= 161)}, 32'd1);
        width_of(1'b0, n);
        chk("bit1_w_ok", {31'b0, (n >= 159 && n <= 161)}, 32'd1);
        n = 0;
        while (!TxRdy && n < 2000) begin @(negedge C); n++; end
        chk("txrdy", {31'b0, TxRdy}, 32'd1);
        bus_rd(A_CON, d);
        chk("con_txdone", d, 32'h09);
        bus_rd(A_CON, d);
        chk("con_txdone_clr", d, 32'h01);

        // 3. receive 0x3C with RxIntEn
        bus_wr(A_CON, 32'h2);
        chk("rxrdy_pre", {31'b0, RxRdy}, 32'd0);
        send_rx(8'h3C, 1'b1);
        chk("rxrdy", {31'b0, RxRdy}, 32'd1);
        check_rxd("rxd_3c");
        @(negedge C);
        chk("rxrdy_drop", {31'b0, RxRdy}, 32'd0);

        // 4. overrun, then frame error
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check_rxd("rxd_overrun");
        bus_rd(A_CON, d);
        chk("con_overrun", d, 32'h42);
        send_rx(8'h55, 1'b0);
        check_rxd("rxd_ferr_keep");
        bus_rd(A_CON, d);
        chk("con_ferr", d, 32'h22);
        bus_rd(A_CON, d);
        chk("con_ferr_clr", d, 32'h02);

        // 5. glitch on Rx, then a clean byte
        @(negedge C); Rx = 1'b0;
        repeat (40) @(negedge C);
        Rx = 1'b1;
        repeat (300) @(negedge C);
        bus_rd(A_CON, d);
        chk("glitch_con", d, 32'h02);
        chk("glitch_rxrdy", {31'b0, RxRdy}, 32'd0);
        send_rx(8'h96, 1'b1);
        check_rxd("rxd_after_glitch");

        // 6. write while busy is dropped; write on the busy-fall cycle is sent
        bus_wr(A_CON, 32'h0);
        bus_wr(A_TXD, 32'h12);
        tx_q.push_back(8'h12);
        repeat (50) @(negedge C);
        bus_rd(A_TXD, d);
        chk("txd_readback", d, 32'h12);
        bus_wr(A_TXD, 32'h34);
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge C); Addr = A_CON; MemRd = 1'b1;
            #1;
            if (!RdData[4]) begin
                MemRd = 1'b0; Addr = A_TXD; WrData = 32'h34; MemWr = 1'b1;
                tx_q.push_back(8'h34);
                found = 1'b1;
                @(negedge C); MemWr = 1'b0;
            end
        end
        MemRd = 1'b0;
        chk("busy_fall_seen", {31'b0, found}, 32'd1);
        repeat (1800) @(negedge C);
        chk("tx_q_drained", tx_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped UART peripheral on the MEM-stage data bus, alongside the RAM, LED, switch, hex and timer decode. It consumes the MEM-stage address, read and write strobes and store data. It returns read data combinationally for the MEM/WB register. It drives the RxRdy/TxRdy interrupt request levels into the CPU's IRQ logic. Fixed format: 8N1, 16x oversampled receiver.

Parameters:
CLK_FREQ, 50000000, core clock frequency in Hz
BAUD, 9600, line rate in bits per second
DIV, CLK_FREQ/(BAUD*16), clocks per oversample tick; must be >= 2
BASE, 32'h4000_0018, byte address of TXD; RXD = BASE+4, CON = BASE+8

Ports:
C  in  1  core clock, rising edge
R  in  1  reset, asynchronous, active-low
Addr  in  32  MEM-stage byte address (EXMEM_ALUOut)
MemRd  in  1  MEM-stage read strobe
MemWr  in  1  MEM-stage write strobe
WrData  in  32  store data (EXMEM_RegB)
RdData  out  32  read data; combinational; 0 when not selected
Rx  in  1  serial input; asynchronous; idle high
Tx  out  1  serial output; idle high
RxRdy  out  1  receive interrupt request, level
TxRdy  out  1  transmit interrupt request, level

Behaviour:
Reset (R low, asynchronous):
- Tx=1; RxRdy=TxRdy=0; all FSMs return to IDLE.
- Tick counter, TXD, RXD and CON are cleared.
- A frame in progress is abandoned and Tx returns high immediately.

Tick generator:
- Free-running counter 0..DIV-1; tick asserts for one cycle when the count is DIV-1, then the counter wraps to 0.

Register map (word address Addr[31:2]; Addr[1:0] ignored):
- TXD, write: WrData[7:0] starts a transmit if the TX FSM is IDLE; ignored if busy. Read returns {24'b0, last written byte}.
- RXD, read: {24'b0, RxData}. Clears RxFull on the rising edge where MemRd is high and RXD is selected. Writes are ignored.
- CON bits:
  - bit0 TxIntEn (r/w)
  - bit1 RxIntEn (r/w)
  - bit2 RxFull (ro)
  - bit3 TxDone (sticky; cleared by a CON read)
  - bit4 TxBusy (ro)
  - bit5 FrameErr (sticky; cleared by a CON read)
  - bit6 Overrun (sticky; cleared by a CON read)
  - A CON write updates bits 1:0 only.
- Any read is combinational in the same cycle. Read side effects take effect at the closing clock edge.

Interrupt outputs (registered, so they change one cycle after the flags):
- RxRdy = RxIntEn & RxFull
- TxRdy = TxIntEn & TxDone

RX path:
- Rx passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a 1->0 transition on rxs -> START, with the tick count cleared.
  - START: after 8 ticks, sample rxs. If 1 (glitch) -> IDLE. If 0 -> DATA.
  - DATA: every 16 ticks, sample one bit, LSB first. After 8 bits -> STOP.
  - STOP: after 16 ticks, sample rxs.
    - rxs=1: load RxData, set RxFull. If RxFull was already set, also set Overrun (new byte overwrites).
    - rxs=0: discard the byte, set FrameErr.
    - Either way -> IDLE. A new start is detectable in the next cycle.
- A RXD read and a frame completion on the same edge: completion wins, so RxFull stays 1 and Overrun is not set.

TX path:
- TX FSM states: IDLE, START, DATA, STOP. Each state/bit lasts 16 ticks.
  - IDLE: Tx=1.
  - START: Tx=0.
  - DATA: 8 bits, LSB first.
  - STOP: Tx=1.
- TxBusy=1 from the cycle after the accepted write until the stop bit ends. At the end of STOP, set TxDone and return to IDLE.
- A CON read and a TxDone set on the same edge: the set wins.
- Back-to-back: a TXD write accepted in the cycle TxBusy falls starts the next frame. Line idle between frames is at least 0 bit times.

Test Plan:
- Sim params CLK_FREQ=1600000, BAUD=10000 (DIV=10, 160 clocks/bit).
1. Reset: hold R low mid-transmit -> Tx=1, RdData(CON)=0, RxRdy=TxRdy=0 within the same cycle; after release, Tx stays 1.
2. TX: write 0x1 to CON, write 0xA5 to TXD -> Tx shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each 160±1 clocks. TxRdy rises after stop. A CON read returns 0x09, then 0x01.
3. RX: drive byte 0x3C at 10000 baud with CON=0x2 -> RxRdy=1 about 1.5 clocks after the stop-bit sample. RXD read returns 0x3C; RxRdy drops the following cycle.
4. Overrun/frame error: send 0x11 then 0x22 without reading -> RXD=0x22 and CON bit6=1. Send 0x55 with stop bit 0 -> RXD unchanged and CON bit5=1.
5. Glitch: a 40-clock low pulse on Rx -> no byte received, FSM back in IDLE, CON bit2=0.
6. Busy write: write 0x12, then 0x34 while TxBusy -> only 0x12 appears on Tx. A 0x34 write on the TxBusy-fall cycle is transmitted next.
